// File: rtl/spi_byte_engine.sv
// SPI mode-0 master byte engine.
// Sends one byte MSB first on mosi and collects one byte from miso, paced by an
// external SCK generator. The generator is enabled through work, and its sck is
// fed back in here.
//
// Parameters
//   SETUP_CYCLES : clk cycles from ss_n falling to work rising (0 behaves as 1)
//   HOLD_CYCLES  : clk cycles from work falling to ss_n rising (0 behaves as 1)
// Ports
//   clk, rst     : system clock; asynchronous active-high reset
//   start        : one-cycle request, accepted only while idle
//   tx_data      : byte to send, captured when start is accepted
//   sck, miso    : serial clock from the generator (idle low); slave data
//   work         : SCK generator enable, high during the shift phase
//   mosi, ss_n   : serial data out; active-low slave select
//   rx_data      : last complete received byte
//   busy, done   : transfer in progress; one-cycle completion pulse
module spi_byte_engine #(
   parameter int unsigned SETUP_CYCLES = 4,
   parameter int unsigned HOLD_CYCLES  = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] tx_data,
   input  logic       sck,
   input  logic       miso,
   output logic       work,
   output logic       mosi,
   output logic       ss_n,
   output logic [7:0] rx_data,
   output logic       busy,
   output logic       done
);

   localparam int unsigned MaxCycles = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
   // The counter only has to reach MaxCycles-1.
   localparam int unsigned CntW = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
   localparam logic [CntW-1:0] SetupLast = (SETUP_CYCLES > 0) ? CntW'(SETUP_CYCLES - 1) : '0;
   localparam logic [CntW-1:0] HoldLast  = (HOLD_CYCLES > 0) ? CntW'(HOLD_CYCLES - 1) : '0;

   typedef enum logic [1:0] {StIdle, StSetup, StShift, StHold} state_e;

   state_e          state_q, state_d;
   logic            sck_q;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [3:0]      bit_cnt_q, bit_cnt_d;
   logic [7:0]      tx_sh_q, tx_sh_d;
   logic [7:0]      rx_sh_q, rx_sh_d;
   logic [7:0]      rx_data_q, rx_data_d;
   logic            done_q, done_d;

   logic sck_rise, sck_fall, setup_end, hold_end, last_rise;

   assign sck_rise  = sck & ~sck_q;
   assign sck_fall  = ~sck & sck_q;
   assign setup_end = (cnt_q == SetupLast);
   assign hold_end  = (cnt_q == HoldLast);
   assign last_rise = sck_rise && (bit_cnt_q == 4'd7);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (start)     state_d = StSetup;
         StSetup: if (setup_end) state_d = StShift;
         StShift: if (last_rise) state_d = StHold;
         StHold:  if (hold_end)  state_d = StIdle;
         default:                state_d = StIdle;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sck_q     <= 1'b0;
         cnt_q     <= '0;
         bit_cnt_q <= '0;
         tx_sh_q   <= '0;
         rx_sh_q   <= '0;
         rx_data_q <= '0;
         done_q    <= 1'b0;
      end else begin
         // Held clear while idle so a stale high sck never reads as a fall.
         sck_q     <= (state_q == StIdle) ? 1'b0 : sck;
         cnt_q     <= cnt_d;
         bit_cnt_q <= bit_cnt_d;
         tx_sh_q   <= tx_sh_d;
         rx_sh_q   <= rx_sh_d;
         rx_data_q <= rx_data_d;
         done_q    <= done_d;
      end
   end

   // Datapath next-state
   always_comb begin
      cnt_d     = cnt_q;
      bit_cnt_d = bit_cnt_q;
      tx_sh_d   = tx_sh_q;
      rx_sh_d   = rx_sh_q;
      rx_data_d = rx_data_q;
      done_d    = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) begin
               tx_sh_d   = tx_data;
               rx_sh_d   = '0;
               cnt_d     = '0;
               bit_cnt_d = '0;
            end
         end
         StSetup: begin
            cnt_d = setup_end ? '0 : cnt_q + CntW'(1);
         end
         StShift: begin
            if (sck_rise) begin
               rx_sh_d   = {rx_sh_q[6:0], miso};
               bit_cnt_d = bit_cnt_q + 4'd1;
            end else if (sck_fall && (bit_cnt_q < 4'd8)) begin
               tx_sh_d = {tx_sh_q[6:0], 1'b0};
            end
         end
         StHold: begin
            if (hold_end) begin
               cnt_d     = '0;
               rx_data_d = rx_sh_q;
               done_d    = 1'b1;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: ;
      endcase
   end

   // Outputs; mosi is the shifter MSB, so it already shows tx_data[7] in the first SETUP cycle.
   always_comb begin
      work    = (state_q == StShift);
      ss_n    = (state_q == StIdle);
      busy    = (state_q != StIdle);
      mosi    = tx_sh_q[7];
      rx_data = rx_data_q;
      done    = done_q;
   end

endmodule

// File: tb/tb_spi_byte_engine.sv
// Bench for spi_byte_engine: lane 0 uses 4/4 setup/hold, lane 1 uses 0/0.
// Each lane has its own SCK generator, a transaction-level model and a per-cycle compare.
module tb_spi_byte_engine;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       loop;
   logic       miso_fix;
   logic [7:0] tx_data;
   bit         chk_en = 1'b0;
   int         errors = 0;
   int         checks = 0;

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : lane
      localparam int S  = (g == 0) ? 4 : 0;
      localparam int H  = (g == 0) ? 4 : 0;
      localparam int S1 = (S == 0) ? 1 : S;
      localparam int H1 = (H == 0) ? 1 : H;

      logic       sck, miso, work, mosi, ss_n, busy, done;
      logic [7:0] rx_data;
      int         div;

      assign miso = loop ? mosi : miso_fix;

      spi_byte_engine #(.SETUP_CYCLES(S), .HOLD_CYCLES(H)) dut (
         .clk     (clk),
         .rst     (rst),
         .start   (start),
         .tx_data (tx_data),
         .sck     (sck),
         .miso    (miso),
         .work    (work),
         .mosi    (mosi),
         .ss_n    (ss_n),
         .rx_data (rx_data),
         .busy    (busy),
         .done    (done)
      );

      // SCK generator: toggles every second clk while work is high, otherwise parks low.
      always @(posedge clk or posedge rst) begin
         if (rst || !work) begin
            sck <= 1'b0;
            div <= 0;
         end else if (div == 1) begin
            sck <= ~sck;
            div <= 0;
         end else begin
            div <= div + 1;
         end
      end

      // Observers
      int         rises = 0;
      logic [7:0] mosi_log = 8'h00;
      always @(posedge sck) begin
         rises++;
         mosi_log = {mosi_log[6:0], mosi};
      end

      int         done_cnt = 0, acc_cnt = 0, ssn_run = 0, last_gap = -1, sw_cnt = 0, won_gap = -1;
      bit         sw_armed = 1'b0;
      logic       ssn_prev = 1'b1;
      logic [7:0] done_rx [16];
      always @(negedge clk) begin
         if (done === 1'b1) begin
            done_rx[done_cnt % 16] = rx_data;
            done_cnt++;
         end
         if (ssn_prev === 1'b1 && ss_n === 1'b0) begin
            acc_cnt++;
            last_gap = ssn_run;
            ssn_run  = 0;
            sw_cnt   = 0;
            sw_armed = 1'b1;
         end else begin
            if (ss_n === 1'b1) ssn_run++;
            if (sw_armed) sw_cnt++;
         end
         if (sw_armed && work === 1'b1) begin
            won_gap  = sw_cnt;
            sw_armed = 1'b0;
         end
         ssn_prev = ss_n;
      end

      // Transaction model: a transfer is an accept edge, a fixed setup span, eight
      // detected sck rises and a fixed hold span; outputs follow from those times.
      int         ecount = 0, m_a = 0, m_r8 = -1, m_rises = 0, m_falls = 0;
      bit         m_act = 1'b0;
      logic       m_psck = 1'b0;
      logic [7:0] m_tx = 8'h00, m_sh = 8'h00;
      logic       e_work = 1'b0, e_ssn = 1'b1, e_busy = 1'b0, e_done = 1'b0, e_mosi = 1'b0;
      logic [7:0] e_rx = 8'h00;

      always @(posedge clk or posedge rst) begin
         if (rst) begin
            m_act  = 1'b0;
            m_r8   = -1;
            e_work = 1'b0;
            e_ssn  = 1'b1;
            e_busy = 1'b0;
            e_done = 1'b0;
            e_mosi = 1'b0;
            e_rx   = 8'h00;
         end else begin
            ecount++;
            e_done = 1'b0;
            if (!m_act) begin
               if (start) begin
                  m_act   = 1'b1;
                  m_a     = ecount;
                  m_tx    = tx_data;
                  m_rises = 0;
                  m_falls = 0;
                  m_r8    = -1;
                  m_sh    = 8'h00;
                  m_psck  = 1'b0;
                  e_mosi  = tx_data[7];
               end
            end else begin
               if (m_r8 < 0 && ecount > m_a + S1) begin
                  if (sck && !m_psck) begin
                     m_sh = {m_sh[6:0], (loop ? e_mosi : miso_fix)};
                     m_rises++;
                     if (m_rises == 8) m_r8 = ecount;
                  end else if (!sck && m_psck && m_falls < 7) begin
                     m_falls++;
                     e_mosi = m_tx[7-m_falls];
                  end
               end
               m_psck = sck;
               if (m_r8 >= 0 && ecount == m_r8 + H1) begin
                  m_act  = 1'b0;
                  e_done = 1'b1;
                  e_rx   = m_sh;
               end
            end
            e_busy = m_act;
            e_ssn  = !m_act;
            e_work = m_act && m_r8 < 0 && ecount >= m_a + S1;
         end
      end

      always @(negedge clk) begin
         if (chk_en && !rst) begin
            chk($sformatf("lane%0d work", g), work, e_work);
            chk($sformatf("lane%0d ss_n", g), ss_n, e_ssn);
            chk($sformatf("lane%0d busy", g), busy, e_busy);
            chk($sformatf("lane%0d done", g), done, e_done);
            chk($sformatf("lane%0d mosi", g), mosi, e_mosi);
            chk($sformatf("lane%0d rx_data", g), rx_data, e_rx);
         end
      end
   end

   int d_base[2];
   int r_base[2];

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic peek(input int g, output int dc, output int rc, output int gap, output int wg,
                       output logic [7:0] ml, output logic [7:0] rx);
      if (g == 0) begin
         dc = lane[0].done_cnt; rc = lane[0].rises; gap = lane[0].last_gap;
         wg = lane[0].won_gap;  ml = lane[0].mosi_log; rx = lane[0].rx_data;
      end else begin
         dc = lane[1].done_cnt; rc = lane[1].rises; gap = lane[1].last_gap;
         wg = lane[1].won_gap;  ml = lane[1].mosi_log; rx = lane[1].rx_data;
      end
   endtask

   function automatic logic [7:0] done_val(input int g, input int i);
      return (g == 0) ? lane[0].done_rx[i % 16] : lane[1].done_rx[i % 16];
   endfunction

   task automatic snap();
      for (int g = 0; g < 2; g++) begin
         int gap, wg;
         logic [7:0] ml, rx;
         peek(g, d_base[g], r_base[g], gap, wg, ml, rx);
      end
   endtask

   task automatic pulse(input logic [7:0] b);
      tx_data = b;
      start   = 1'b1;
      step();
      start   = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((lane[0].busy !== 1'b0 || lane[1].busy !== 1'b0) && n < 2000) begin
         step();
         n++;
      end
      chk({tag, " idle in time"}, 32'(n < 2000), 32'd1);
      step();
   endtask

   task automatic post(input string tag, input logic [7:0] exp_ml, input logic [7:0] exp_rx,
                       input int exp_dd);
      for (int g = 0; g < 2; g++) begin
         int dc, rc, gap, wg;
         logic [7:0] ml, rx;
         peek(g, dc, rc, gap, wg, ml, rx);
         chk($sformatf("%s lane%0d done count", tag, g), dc - d_base[g], exp_dd);
         chk($sformatf("%s lane%0d sck rises", tag, g), rc - r_base[g], 8 * exp_dd);
         chk($sformatf("%s lane%0d mosi bits", tag, g), ml, exp_ml);
         chk($sformatf("%s lane%0d rx_data", tag, g), rx, exp_rx);
      end
   endtask

   task automatic reset_chk(input string tag, input logic w, input logic s, input logic b,
                            input logic d, input logic m, input logic [7:0] r);
      chk({tag, " work"}, w, 1'b0);
      chk({tag, " ss_n"}, s, 1'b1);
      chk({tag, " busy"}, b, 1'b0);
      chk({tag, " done"}, d, 1'b0);
      chk({tag, " mosi"}, m, 1'b0);
      chk({tag, " rx_data"}, r, 8'h00);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      int n, dc, rc, gap, wg;
      logic [7:0] ml, rx;
      rst = 1'b1; start = 1'b0; tx_data = 8'h00; loop = 1'b0; miso_fix = 1'b0;
      repeat (3) step();
      reset_chk("reset lane0", lane[0].work, lane[0].ss_n, lane[0].busy, lane[0].done,
                lane[0].mosi, lane[0].rx_data);
      reset_chk("reset lane1", lane[1].work, lane[1].ss_n, lane[1].busy, lane[1].done,
                lane[1].mosi, lane[1].rx_data);
      rst = 1'b0;
      chk_en = 1'b1;
      repeat (2) step();

      // Loopback A5; also the ss_n-to-work gap for 4-cycle and 0-cycle setup
      loop = 1'b1;
      snap();
      pulse(8'hA5);
      wait_idle("a5");
      post("a5", 8'hA5, 8'hA5, 1);
      peek(0, dc, rc, gap, wg, ml, rx);
      chk("a5 lane0 setup gap", wg, 4);
      peek(1, dc, rc, gap, wg, ml, rx);
      chk("a5 lane1 setup gap", wg, 1);

      // miso tied high, then low
      loop = 1'b0;
      miso_fix = 1'b1;
      snap();
      pulse(8'h3C);
      wait_idle("miso1");
      post("miso1", 8'h3C, 8'hFF, 1);
      miso_fix = 1'b0;
      snap();
      pulse(8'h3C);
      wait_idle("miso0");
      post("miso0", 8'h3C, 8'h00, 1);

      // start held during a transfer with a different tx_data is ignored
      loop = 1'b1;
      snap();
      pulse(8'hC3);
      tx_data = 8'h00;
      start = 1'b1;
      repeat (20) step();
      start = 1'b0;
      wait_idle("busy start");
      post("busy start", 8'hC3, 8'hC3, 1);

      // Reset after the 4th sck rise aborts with no done and rx_data cleared
      snap();
      pulse(8'h5A);
      n = 0;
      while (lane[0].rises - r_base[0] < 4 && n < 500) begin
         step();
         n++;
      end
      chk("abort 4th rise reached", 32'(n < 500), 32'd1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      reset_chk("abort lane0", lane[0].work, lane[0].ss_n, lane[0].busy, lane[0].done,
                lane[0].mosi, lane[0].rx_data);
      reset_chk("abort lane1", lane[1].work, lane[1].ss_n, lane[1].busy, lane[1].done,
                lane[1].mosi, lane[1].rx_data);
      step();
      step();
      rst = 1'b0;
      repeat (5) step();
      for (int g = 0; g < 2; g++) begin
         peek(g, dc, rc, gap, wg, ml, rx);
         chk($sformatf("abort lane%0d no done", g), dc - d_base[g], 0);
         chk($sformatf("abort lane%0d rx_data", g), rx, 8'h00);
      end

      // First start after reset is accepted normally
      snap();
      pulse(8'h96);
      wait_idle("post reset");
      post("post reset", 8'h96, 8'h96, 1);

      // Back-to-back with start held: 81 then 7E, one ss_n-high cycle between
      snap();
      n = lane[0].acc_cnt;
      tx_data = 8'h81;
      start = 1'b1;
      step();
      tx_data = 8'h7E;
      while (lane[0].acc_cnt - n < 2 && n > -1 && lane[0].acc_cnt - n >= 0 && checks >= 0) begin
         if (lane[0].ecount > 100000) break;
         step();
         if (lane[0].acc_cnt - n < 2 && lane[0].rises - r_base[0] > 40) break;
      end
      chk("b2b second accept seen", lane[0].acc_cnt - n, 2);
      start = 1'b0;
      wait_idle("b2b");
      post("b2b", 8'h7E, 8'h7E, 2);
      for (int g = 0; g < 2; g++) begin
         peek(g, dc, rc, gap, wg, ml, rx);
         chk($sformatf("b2b lane%0d first rx", g), done_val(g, d_base[g]), 8'h81);
         chk($sformatf("b2b lane%0d second rx", g), done_val(g, d_base[g] + 1), 8'h7E);
         chk($sformatf("b2b lane%0d ss_n high gap", g), gap, 1);
      end

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spi_byte_engine.md
SPI_BYTE_ENGINE -- requirements
Module: spi_byte_engine

Interface
REQ-001 SHALL have parameter SETUP_CYCLES, default 4: clk cycles between ss_n falling and work rising.
REQ-002 SHALL have parameter HOLD_CYCLES, default 4: clk cycles between work falling and ss_n rising.
REQ-003 SHALL have port clk, input, 1: single system clock; all logic on posedge clk.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port start, input, 1: one-cycle request to transfer tx_data.
REQ-006 SHALL have port tx_data, input, 8: byte to transmit, MSB first.
REQ-007 SHALL have port sck, input, 1: serial clock from the SCK generator stage, idle low, synchronous to clk.
REQ-008 SHALL have port miso, input, 1: serial data from the slave.
REQ-009 SHALL have port work, output, 1: enable to the SCK generator.
REQ-010 SHALL have port mosi, output, 1: serial data to the slave.
REQ-011 SHALL have port ss_n, output, 1: slave select, active-low.
REQ-012 SHALL have port rx_data, output, 8: last received byte.
REQ-013 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-014 SHALL have port done, output, 1: one-cycle pulse at end of transfer.

Function
REQ-015 SHALL implement SPI mode 0: mosi changes on sck falling edge; miso sampled on sck rising edge; MSB first.
REQ-016 SHALL detect sck edges with one register sck_q: rise = sck & ~sck_q; fall = ~sck & sck_q. sck_q is cleared in IDLE.
REQ-017 SHALL use FSM states IDLE, SETUP, SHIFT, HOLD.
REQ-018 IDLE: start=1 -> latch tx_data into tx_sh, drive mosi=tx_data[7], ss_n=0, clear the counters, go to SETUP. start=0 -> remain in IDLE.
REQ-019 SETUP: count SETUP_CYCLES clk cycles, then set work=1 and go to SHIFT.
REQ-020 SHIFT, on rise: rx_sh = {rx_sh[6:0], miso}; bit_cnt increments (4-bit, 0..8).
REQ-021 SHIFT, on fall with bit_cnt<8: tx_sh shifts left by one; mosi = new tx_sh[7].
REQ-022 SHIFT: the clk cycle in which the 8th rise is detected SHALL set work=0 next cycle and go to HOLD; no further shift occurs.
REQ-023 HOLD: count HOLD_CYCLES clk cycles, then set ss_n=1, rx_data=rx_sh, done=1 for exactly one cycle, and go to IDLE.
REQ-024 done SHALL be high in the first IDLE cycle after HOLD; start asserted in that cycle SHALL be accepted (back-to-back transfers).
REQ-025 start asserted while busy=1 SHALL be ignored without queuing; tx_data is not re-sampled.
REQ-026 rx_data SHALL change only at transfer completion and hold its value otherwise.
REQ-027 SETUP and HOLD counters SHALL be wide enough for the parameter values. A parameter value of 0 SHALL mean a 1-cycle pass-through state.
REQ-028 A rise and a fall cannot coincide, because sck is a single level. bit_cnt SHALL never exceed 8.

Reset
REQ-029 rst=1 SHALL immediately force: state=IDLE, work=0, ss_n=1, mosi=0, busy=0, done=0, rx_data=8'h00, all counters and shift registers 0.
REQ-030 rst asserted mid-transfer SHALL abort the transfer with no done pulse. rx_data keeps its reset value, not partial data.
REQ-031 After rst deasserts, the first start SHALL be accepted normally.

Verification
REQ-032 tx_data=8'hA5, miso looped to mosi, start pulse -> 8 sck rises; mosi bit sequence 1,0,1,0,0,1,0,1; done pulse once; rx_data=8'hA5; ss_n low for the whole window.
REQ-033 tx_data=8'h3C, miso tied 1 -> rx_data=8'hFF. Then miso tied 0 and start again -> rx_data=8'h00.
REQ-034 start repeated every cycle during a transfer with tx_data=8'h00 -> exactly one done pulse; the first byte's mosi sequence is unaffected.
REQ-035 rst pulsed after the 4th sck rise -> same-cycle (async) work=0, ss_n=1, busy=0; no done pulse; rx_data=8'h00.
REQ-036 start held high, tx_data=8'h81 then 8'h7E, loopback -> two transfers with ss_n high for exactly one cycle between them; rx_data 8'h81 then 8'h7E.
REQ-037 SETUP_CYCLES=0, HOLD_CYCLES=0 -> the transfer completes correctly with rx_data matching loopback; ss_n-to-work gap is 1 cycle.
